pwm_duty_capture: RTL
=====================

Name: pwm_duty_capture

Overview:
- Receive-side counterpart to the PWM duty generator.
- Samples an external PWM waveform and measures high time and period in clock cycles.
- Converts each measurement to a duty cycle in 10% steps (0..10) with a fixed-latency sequential divider.
- Sits on a TT user input pin so the generator's duty steps can be checked on silicon or in loopback.

Parameters:
- CNT_W, 16: width of high/period counters and count outputs.
- SYNC_STAGES, 2: input synchronizer depth (min 2).
- TIMEOUT, 65535: cycles without a rising edge before a stuck condition is declared; must be < 2^CNT_W.
- DEGLITCH, 3: stable-cycle count for the optional filter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable (TT ena)
- pwm_in  in  1  asynchronous PWM input
- meas_valid  out  1  one-cycle pulse: new measurement on outputs
- high_cnt  out  CNT_W  high cycles of last complete period
- period_cnt  out  CNT_W  cycles of last complete period
- duty_tenths  out  4  floor(high_cnt*10/period_cnt), range 0..10
- stuck_hi  out  1  level: input held high for TIMEOUT cycles
- stuck_lo  out  1  level: input held low for TIMEOUT cycles
- short_err  out  1  one-cycle pulse: period < 5 cycles, capture dropped

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FSM=IDLE, counters 0, divider idle.
- Input conditioning:
  - pwm_s is pwm_in through SYNC_STAGES flops; pwm_q is pwm_s delayed 1 cycle.
  - rise = pwm_s & ~pwm_q.
- Measure FSM:
  - IDLE: on rise, set ctr_p=1 and ctr_h=1, go ARMED. Counts start only on a rise; no meas_valid from IDLE.
  - ARMED, no rise: ctr_p += 1; ctr_h += 1 when pwm_s=1.
  - ARMED, rise:
    - If ctr_p >= 5: capture high=ctr_h and period=ctr_p, start divider, then reload both counters to 1.
    - If ctr_p < 5: drop the capture, pulse short_err, reload both counters to 1.
  - ARMED, ctr_p == TIMEOUT with no rise: go IDLE; stuck_hi=pwm_s, stuck_lo=~pwm_s; duty_tenths=10 if high, 0 if low; high_cnt and period_cnt hold; no meas_valid.
  - Rise and timeout in the same cycle: rise wins.
  - Any rise clears stuck_hi and stuck_lo.
- Divider (restoring, 4 quotient bits):
  - Capture cycle N: load num=high*10 (CNT_W+4 bits) and den=period.
  - Cycles N+1..N+4: one quotient bit per cycle, MSB first, comparing num against den<<k for k=3..0.
  - Cycle N+5: meas_valid=1; high_cnt, period_cnt and duty_tenths update together and hold until the next update.
  - Latency is always 5 cycles; min period 5 keeps the divider free before the next capture.
  - high_cnt <= period_cnt by construction, so the quotient is always <= 10.
- Enable:
  - ena=0: on the next clock FSM goes IDLE, counters clear, in-flight divide is aborted (no meas_valid); outputs hold last values.
  - ena rising: the first rise only re-arms, exactly as after reset.
- Reset mid-divide: the result is lost; outputs read 0.

Optional Feature:
- Macro: PWM_CAP_DEGLITCH_EN.
- Defined: a stage between the synchronizer and edge detect. The filtered level changes only after the synchronized input differs from it for DEGLITCH consecutive cycles.
  - Filtered level resets to 0.
  - Pulses shorter than DEGLITCH cycles are ignored.
  - All measurements shift by DEGLITCH cycles of latency; period and high counts are unchanged for clean input.
- Undefined: pwm_s feeds the edge detect directly; no filter logic exists.

Test Plan:
- Period 10, high 3, repeated (generator at 30%) -> after first rise, each later rise gives meas_valid 5 cycles later with high_cnt=3, period_cnt=10, duty_tenths=3; sweep generator steps 50/60/70/60/50/40% -> duty 5,6,7,6,5,4.
- Period 20, high 13 -> duty_tenths=6 (floor of 6.5); period 7, high 7 (min low) and high 0 not possible -> high 6 gives 8.
- TIMEOUT=64, pwm_in held 1 after an armed period -> stuck_hi=1 at ctr_p=64, duty_tenths=10, no meas_valid; next rise clears it with no meas_valid; the following rise gives a valid measurement.
- Period 4 toggling -> short_err pulse on each rise, meas_valid never asserted, outputs unchanged.
- Deassert rst_n two cycles after a capture -> outputs 0 immediately, no meas_valid; deassert ena mid-period -> no meas_valid; after re-enable, the second rise produces the first valid measurement.
- With PWM_CAP_DEGLITCH_EN, DEGLITCH=3: 2-cycle glitch inside the low phase -> measurement unchanged (high=3, period=10); without the macro the same stimulus triggers short_err or corrupts the measurement.

Source files
------------

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: measures high time and period of an external PWM input
// in clock cycles and converts each complete period into a duty cycle in
// tenths (0..10) with a 4-step restoring divider.
// Optional build macro: PWM_CAP_DEGLITCH_EN adds a DEGLITCH-cycle stability
// filter between the synchronizer and the edge detector.
module pwm_duty_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535,
  parameter int DEGLITCH    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pwm_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [3:0]       duty_tenths,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic             short_err
);

  localparam int NW = CNT_W + 4;

  typedef enum logic {IDLE, ARMED} state_t;

  state_t               state, state_nx;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                 pwm_s, pwm_lvl, pwm_q, rise;
  logic [CNT_W-1:0]     ctr_p, ctr_h;
  logic                 do_arm, do_count, do_capture, do_short, do_timeout;

  logic                 busy;
  logic [1:0]           step;
  logic [NW-1:0]        rem, den_sh, num_ld;
  logic [CNT_W-1:0]     den, cap_h;
  logic [3:0]           quo;
  logic                 rem_ge;

  // Input synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_r <= '0;
    else        sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
  end

  assign pwm_s = sync_r[SYNC_STAGES-1];

`ifdef PWM_CAP_DEGLITCH_EN
  localparam int DG_W = $clog2(DEGLITCH + 1);
  logic [DG_W-1:0] dg_cnt;
  logic            pwm_f;

  // Filtered level follows pwm_s only after DEGLITCH consecutive differing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_f  <= 1'b0;
      dg_cnt <= '0;
    end else if (pwm_s != pwm_f) begin
      if (dg_cnt == DG_W'(DEGLITCH - 1)) begin
        pwm_f  <= pwm_s;
        dg_cnt <= '0;
      end else begin
        dg_cnt <= dg_cnt + 1'b1;
      end
    end else begin
      dg_cnt <= '0;
    end
  end

  assign pwm_lvl = pwm_f;
`else
  assign pwm_lvl = pwm_s;
`endif

  // Delayed copy of the conditioned level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= pwm_lvl;
  end

  assign rise = pwm_lvl & ~pwm_q;

  // Measure FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Measure FSM next state and per-cycle control strobes; rise beats timeout
  always_comb begin
    state_nx   = state;
    do_arm     = 1'b0;
    do_count   = 1'b0;
    do_capture = 1'b0;
    do_short   = 1'b0;
    do_timeout = 1'b0;
    if (!ena) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nx = ARMED;
            do_arm   = 1'b1;
          end
        end
        ARMED: begin
          if (rise) begin
            do_arm = 1'b1;
            if (ctr_p >= CNT_W'(5)) do_capture = 1'b1;
            else                    do_short   = 1'b1;
          end else if (ctr_p == CNT_W'(TIMEOUT)) begin
            state_nx   = IDLE;
            do_timeout = 1'b1;
          end else begin
            do_count = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Period and high-time counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_p <= '0;
      ctr_h <= '0;
    end else if (!ena || do_timeout) begin
      ctr_p <= '0;
      ctr_h <= '0;
    end else if (do_arm) begin
      ctr_p <= CNT_W'(1);
      ctr_h <= CNT_W'(1);
    end else if (do_count) begin
      ctr_p <= ctr_p + 1'b1;
      if (pwm_lvl) ctr_h <= ctr_h + 1'b1;
    end
  end

  // high*10 as (high<<3)+(high<<1); shifted divisor for the current quotient bit
  assign num_ld = {1'b0, ctr_h, 3'b000} + {3'b000, ctr_h, 1'b0};
  assign den_sh = {4'b0000, den} << (2'd3 - step);
  assign rem_ge = (rem >= den_sh);

  // Divider steps, result publication, error and stuck flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      step        <= '0;
      rem         <= '0;
      den         <= '0;
      cap_h       <= '0;
      quo         <= '0;
      meas_valid  <= 1'b0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      duty_tenths <= '0;
      stuck_hi    <= 1'b0;
      stuck_lo    <= 1'b0;
      short_err   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      short_err  <= 1'b0;
      if (!ena) begin
        busy <= 1'b0;
      end else begin
        if (do_capture) begin
          busy  <= 1'b1;
          step  <= '0;
          rem   <= num_ld;
          den   <= ctr_p;
          cap_h <= ctr_h;
          quo   <= '0;
        end else if (busy) begin
          if (rem_ge) rem <= rem - den_sh;
          quo  <= {quo[2:0], rem_ge};
          step <= step + 1'b1;
          if (step == 2'd3) begin
            busy        <= 1'b0;
            meas_valid  <= 1'b1;
            high_cnt    <= cap_h;
            period_cnt  <= den;
            duty_tenths <= {quo[2:0], rem_ge};
          end
        end
        if (do_short) short_err <= 1'b1;
        if (do_arm) begin
          stuck_hi <= 1'b0;
          stuck_lo <= 1'b0;
        end
        if (do_timeout) begin
          stuck_hi    <= pwm_lvl;
          stuck_lo    <= ~pwm_lvl;
          duty_tenths <= pwm_lvl ? 4'd10 : 4'd0;
        end
      end
    end
  end

endmodule
